// File: rtl/fetch_pkg.sv
// Shared types and default vectors for the IF-stage fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RC_NONE   = 3'd0,
    RC_EXC    = 3'd1,
    RC_ERET   = 3'd2,
    RC_BRANCH = 3'd3,
    RC_JUMP   = 3'd4,
    RC_REPLAY = 3'd5
  } redir_e;

  localparam int          AW_DEF        = 30;
  localparam logic [29:0] RESET_VEC_DEF = 30'h0000_0000;
  localparam logic [29:0] EXC_VEC_DEF   = 30'h0000_0060;

endpackage

// File: rtl/fetch_seq_if.sv
// Bus between the fetch sequencer and its environment (PC counter, imem, pipeline controls).
interface fetch_seq_if #(
  parameter int AW = 30
);
  // Counter
  logic [AW-1:0] cnt_q_i;
  logic          cnt_ld_o;
  logic          cnt_ce_o;
  logic          cnt_ud_o;
  logic [AW-1:0] cnt_d_o;
  // Instruction memory: request is level; ack qualifies the word at imem_addr_o that cycle.
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i;
  // Pipeline controls
  logic          stall_i;
  logic          halt_i;
  logic          exc_i;
  logic          eret_i;
  logic [AW-1:0] epc_i;
  logic          br_taken_i;
  logic [AW-1:0] br_tgt_i;
  logic          jmp_i;
  logic [AW-1:0] jmp_tgt_i;
  logic          replay_i;
  // To ID
  logic          if_valid_o;
  logic [AW-1:0] if_pc_o;

  modport master (
    input  cnt_q_i, imem_ack_i, stall_i, halt_i, exc_i, eret_i, epc_i,
           br_taken_i, br_tgt_i, jmp_i, jmp_tgt_i, replay_i,
    output cnt_ld_o, cnt_ce_o, cnt_ud_o, cnt_d_o, imem_req_o, imem_addr_o,
           if_valid_o, if_pc_o
  );

  modport slave (
    output cnt_q_i, imem_ack_i, stall_i, halt_i, exc_i, eret_i, epc_i,
           br_taken_i, br_tgt_i, jmp_i, jmp_tgt_i, replay_i,
    input  cnt_ld_o, cnt_ce_o, cnt_ud_o, cnt_d_o, imem_req_o, imem_addr_o,
           if_valid_o, if_pc_o
  );

endinterface

// File: rtl/fetch_seq.sv
// IF-stage fetch sequencer: one PC-counter command per cycle from redirect/stall/ack.
// Optional FETCH_SEQ_PERF_EN adds saturating stall and redirect counters.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int          AW        = AW_DEF,
  parameter logic [AW-1:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [AW-1:0] EXC_VEC   = EXC_VEC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_seq_if.master   bus,
  output state_e        state_o
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0]   perf_stall_o,
  output logic [31:0]   perf_redir_o
`endif
);

  state_e        state_q, state_d;
  redir_e        cause;
  logic          valid_q, valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          ld, ce, ud, req;
  logic [AW-1:0] d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    cause   = RC_NONE;
    ld      = 1'b0;
    ce      = 1'b0;
    ud      = 1'b1;
    d       = '0;
    req     = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        ld      = 1'b1;
        ce      = 1'b1;
        d       = RESET_VEC;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt_i && !bus.exc_i) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else begin
          req = 1'b1;
          if      (bus.exc_i)      cause = RC_EXC;
          else if (bus.eret_i)     cause = RC_ERET;
          else if (bus.br_taken_i) cause = RC_BRANCH;
          else if (bus.jmp_i)      cause = RC_JUMP;
          else if (bus.replay_i)   cause = RC_REPLAY;
          case (cause)
            RC_EXC:    begin ld = 1'b1; ce = 1'b1; d = EXC_VEC;       end
            RC_ERET:   begin ld = 1'b1; ce = 1'b1; d = bus.epc_i;     end
            RC_BRANCH: begin ld = 1'b1; ce = 1'b1; d = bus.br_tgt_i;  end
            RC_JUMP:   begin ld = 1'b1; ce = 1'b1; d = bus.jmp_tgt_i; end
            RC_REPLAY: begin ce = 1'b1; ud = 1'b0;                    end
            default:   ce = bus.imem_ack_i & ~bus.stall_i;
          endcase
          // A redirect squashes any word acked this cycle; a plain stall holds the ID slot.
          if (cause != RC_NONE) begin
            valid_d = 1'b0;
          end else if (!bus.stall_i) begin
            valid_d = bus.imem_ack_i;
            if (bus.imem_ack_i) pc_d = bus.cnt_q_i;
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        if (bus.exc_i) begin
          ld      = 1'b1;
          ce      = 1'b1;
          d       = EXC_VEC;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign bus.cnt_ld_o    = ld;
  assign bus.cnt_ce_o    = ce;
  assign bus.cnt_ud_o    = ud;
  assign bus.cnt_d_o     = d;
  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = bus.cnt_q_i;
  assign bus.if_valid_o  = valid_q;
  assign bus.if_pc_o     = pc_q;
  assign state_o         = state_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_stall_q, perf_redir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      if (state_q == ST_RUN && bus.stall_i && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (cause != RC_NONE && perf_redir_q != '1)
        perf_redir_q <= perf_redir_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_redir_o = perf_redir_q;
`endif

endmodule
